coeff_loader: RTL and testbench

COEFF_LOADER -- requirements
Module: coeff_loader

---
 rtl/coeff_loader_if.sv | 26 ++
 rtl/coeff_loader.sv | 164 ++++++++++++++++
 tb/tb_coeff_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/coeff_loader_if.sv
// Coefficient loader bus: byte stream in, coefficient bank and status out.
interface coeff_loader_if #(
    parameter int unsigned BITS = 32,
    parameter int unsigned NUM  = 7
);
    logic            start;
    logic [7:0]      s_data;
    logic            s_valid;
    logic            s_ready;
    logic [BITS-1:0] q [NUM-1:0];
    logic            busy;
    logic            done;
    logic            err;

    // Master drives the byte stream and start; it observes the bank and status.
    modport master (
        output start, s_data, s_valid,
        input  s_ready, q, busy, done, err
    );

    // Slave is the loader itself.
    modport slave (
        input  start, s_data, s_valid,
        output s_ready, q, busy, done, err
    );
endinterface

// File: rtl/coeff_loader.sv
// Coefficient loader: assembles little-endian bytes into NUM words of BITS bits.
// Optional feature macro: COEFF_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module coeff_loader #(
    parameter int unsigned BITS = 32,
    parameter int unsigned NUM  = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    coeff_loader_if.slave      bus
);
    localparam int unsigned BYTES = BITS / 8;
    localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned IW    = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int unsigned OFFW  = BCW + 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
`ifdef COEFF_LOADER_CHECKSUM_EN
        ST_CHECK = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [BITS-1:0] shadow_q, shadow_d;
    logic [BITS-1:0] q_q [NUM-1:0];
    logic [BITS-1:0] q_d [NUM-1:0];
    logic            done_q, done_d;
    logic            s_ready_q, s_ready_d;
    logic            busy_q, busy_d;
`ifdef COEFF_LOADER_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
    logic            err_q, err_d;
`endif

    logic [BITS-1:0] word_c;
    logic [OFFW-1:0] off_c;
    logic            xfer_c;
    logic            last_byte_c;
    logic            last_word_c;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        q_d        = q_q;
        done_d     = done_q;
`ifdef COEFF_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        err_d      = err_q;
`endif
        xfer_c      = bus.s_valid && s_ready_q;
        off_c       = {byte_cnt_q, 3'b000};
        word_c      = shadow_q;
        word_c[off_c +: 8] = bus.s_data;
        last_byte_c = (byte_cnt_q == BCW'(BYTES - 1));
        last_word_c = (idx_q == IW'(NUM - 1));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d    = ST_LOAD;
                    byte_cnt_d = '0;
                    idx_d      = '0;
                    shadow_d   = '0;
                    done_d     = 1'b0;
`ifdef COEFF_LOADER_CHECKSUM_EN
                    sum_d      = '0;
                    err_d      = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (xfer_c) begin
                    shadow_d = word_c;
`ifdef COEFF_LOADER_CHECKSUM_EN
                    sum_d    = sum_q + bus.s_data;
`endif
                    if (last_byte_c) begin
                        // Whole word commits at once so q never shows a partial word.
                        q_d[idx_q] = word_c;
                        byte_cnt_d = '0;
                        if (last_word_c) begin
                            idx_d = '0;
`ifdef COEFF_LOADER_CHECKSUM_EN
                            state_d = ST_CHECK;
`else
                            state_d = ST_DONE;
                            done_d  = 1'b1;
`endif
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
`ifdef COEFF_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer_c) begin
                    err_d   = (bus.s_data != sum_q);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

`ifdef COEFF_LOADER_CHECKSUM_EN
        s_ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
`else
        s_ready_d = (state_d == ST_LOAD);
`endif
        busy_d = s_ready_d;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            for (int i = 0; i < int'(NUM); i++) q_q[i] <= '0;
            done_q     <= 1'b0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef COEFF_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            q_q        <= q_d;
            done_q     <= done_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
`ifdef COEFF_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.q       = q_q;
`ifdef COEFF_LOADER_CHECKSUM_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif
endmodule

// File: tb/tb_coeff_loader.sv
// Scoreboard bench for coeff_loader (BITS=32, NUM=7).
module tb_coeff_loader;
    localparam int unsigned BITS = 32;
    localparam int unsigned NUM  = 7;

    typedef struct {
        logic [31:0] w [7];
        logic        err;
    } exp_t;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;
    exp_t sb [$];

    coeff_loader_if #(.BITS(BITS), .NUM(NUM)) bus ();

    coeff_loader #(.BITS(BITS), .NUM(NUM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Expected word i of a load whose bytes count up from base.
    function automatic logic [31:0] mk_word(input logic [7:0] base, input int i);
        logic [7:0] b;
        b = base + 8'(4 * i);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic push_exp(input logic [7:0] base, input logic e);
        exp_t x;
        for (int i = 0; i < 7; i++) x.w[i] = mk_word(base, i);
        x.err = e;
        sb.push_back(x);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.s_ready) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout: got s_ready=0 expected 1 for byte %02h", b);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic send_run(input logic [7:0] base, input int n, input bit gap);
        for (int k = 0; k < n; k++) begin
            send_byte(base + 8'(k));
            if (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        for (int i = 0; i < 7; i++) chk({tag, "_q"}, bus.q[i], 32'h0);
        chk({tag, "_ready"}, 32'(bus.s_ready), 32'h0);
        chk({tag, "_busy"},  32'(bus.busy),    32'h0);
        chk({tag, "_done"},  32'(bus.done),    32'h0);
        chk({tag, "_err"},   32'(bus.err),     32'h0);
    endtask

    task automatic finish_load(input logic [7:0] csum);
`ifdef COEFF_LOADER_CHECKSUM_EN
        chk("check_busy", 32'(bus.busy), 32'h1);
        send_byte(csum);
`else
        chk("csum_unused", 32'(csum), 32'(csum));
        chk("no_extra_ready", 32'(bus.s_ready), 32'h0);
`endif
        chk("done_after_last", 32'(bus.done), 32'h1);
        chk("busy_after_last", 32'(bus.busy), 32'h0);
    endtask

    // Monitor: each rising edge of done is one completed load to score.
    logic done_prev;
    always @(negedge clk) begin
        if (reset_n) begin
            done_prev <= 1'b0;
        end else begin
            if (bus.done && !done_prev) begin
                if (sb.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL sb_empty: got done=1 expected no completion");
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    for (int i = 0; i < 7; i++) chk($sformatf("sb_q%0d", i), bus.q[i], x.w[i]);
                    chk("sb_err", 32'(bus.err), 32'(x.err));
                end
            end
            done_prev <= bus.done;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        errors      = 0;
        checks      = 0;
        reset_n     = 1'b1;
        bus.start   = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset_n = 1'b0;

        // s_valid while idle must not consume anything.
        bus.s_data  = 8'hEE;
        bus.s_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_ready", 32'(bus.s_ready), 32'h0);
        bus.s_valid = 1'b0;

        // Back-to-back load 0x01..0x1C.
        pulse_start();
        chk("load_busy", 32'(bus.busy), 32'h1);
        push_exp(8'h01, 1'b0);
        send_run(8'h01, 28, 1'b0);
        finish_load(8'h96);
        chk("q0_const", bus.q[0], 32'h04030201);
        chk("q6_const", bus.q[6], 32'h1C1B1A19);
        repeat (2) @(negedge clk);
        chk("done_sticky", 32'(bus.done), 32'h1);

        // Restart from DONE, then the same bytes with s_valid toggling.
        pulse_start();
        chk("restart_done", 32'(bus.done), 32'h0);
        chk("restart_busy", 32'(bus.busy), 32'h1);
`ifdef COEFF_LOADER_CHECKSUM_EN
        push_exp(8'h01, 1'b1);
        send_run(8'h01, 28, 1'b1);
        finish_load(8'h97);
`else
        push_exp(8'h01, 1'b0);
        send_run(8'h01, 28, 1'b1);
        finish_load(8'h00);
`endif

        // Partial load with a stray start, then abort by reset.
        pulse_start();
        send_run(8'h50, 6, 1'b0);
        pulse_start();
        chk("mid_start_busy", 32'(bus.busy), 32'h1);
        send_run(8'h56, 4, 1'b0);
        chk("partial_q0", bus.q[0], 32'h53525150);
        chk("partial_q1", bus.q[1], 32'h57565554);
        chk("partial_q2_old", bus.q[2], 32'h0C0B0A09);
        chk("partial_q6_old", bus.q[6], 32'h1C1B1A19);
        reset_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        check_cleared("abort");
        @(negedge clk);
        chk("abort_idle_ready", 32'(bus.s_ready), 32'h0);

        // Fresh load after abort; 0xA0..0xBB sums to 0x12FA.
        pulse_start();
        push_exp(8'hA0, 1'b0);
        send_run(8'hA0, 28, 1'b0);
        finish_load(8'hFA);
        chk("fresh_q0", bus.q[0], 32'hA3A2A1A0);
        chk("fresh_q6", bus.q[6], 32'hBBBAB9B8);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
